// File: rtl/dac_8bit_bipolar.sv
// dac_8bit_bipolar: clocked bipolar 8-bit DAC, two's-complement code in, IEEE-754 double volts out.
// Define DAC_SLEW_LIMIT_EN to compile in the SLEW state (output ramps SLEW_STEP codes per cycle).
module dac_8bit_bipolar #(
   parameter int CONV_CYCLES = 10,
   parameter int SLEW_STEP   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic [63:0] analog_out,
   output logic        dout_valid,
   output logic        conv_done
);
   localparam int CW = CONV_CYCLES > 1 ? $clog2(CONV_CYCLES) : 1;

   if (CONV_CYCLES < 1) begin : g_bad_conv
      $error("CONV_CYCLES must be >= 1");
   end
   if (SLEW_STEP < 1 || SLEW_STEP > 255) begin : g_bad_step
      $error("SLEW_STEP must be 1..255");
   end

   // Volts = code * 5/64, so the magnitude is an integer n scaled by 2^-6; full scale is n = 640.
   function automatic logic [63:0] to_bits(input logic [7:0] c);
      logic [7:0]  a;
      logic [9:0]  n;
      logic [51:0] f;
      int          p;
      a = c[7] ? 8'(-c) : c;
      n = (c == 8'h7F || c == 8'h81 || c == 8'h80) ? 10'd640 : 10'(a) * 10'd5;
      p = 0;
      for (int i = 0; i < 10; i++) if (n[i]) p = i;
      f = 52'(n) << (52 - p);
      return n == '0 ? 64'h0 : {c[7], 11'(1017 + p), f};
   endfunction

   typedef enum logic [1:0] {IDLE, CONVERT, HOLD `ifdef DAC_SLEW_LIMIT_EN , SLEW `endif} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [7:0]    target_q, cur_q, cur_d;
   logic [63:0]   analog_q;
   logic          dout_valid_q, conv_done_q, done_d, busy;

`ifdef DAC_SLEW_LIMIT_EN
   localparam logic signed [8:0] STEP = 9'(SLEW_STEP);
   logic signed [8:0] diff, nxt;
   always_comb begin
      diff   = $signed({target_q[7], target_q}) - $signed({cur_q[7], cur_q});
      done_d = diff <= STEP && diff >= -STEP;
      nxt    = $signed({cur_q[7], cur_q}) + (diff[8] ? -STEP : STEP);
      cur_d  = done_d ? target_q : nxt[7:0];
   end
   assign busy = state_q == CONVERT || state_q == SLEW;
`else
   always_comb begin
      done_d = 1'b1;
      cur_d  = target_q;
   end
   assign busy = state_q == CONVERT;
`endif

   assign din_ready  = rst_n && !busy;
   assign analog_out = analog_q;
   assign dout_valid = dout_valid_q;
   assign conv_done  = conv_done_q;

   always_ff @(posedge clk) begin
      conv_done_q <= 1'b0;
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         target_q     <= '0;
         cur_q        <= '0;
         analog_q     <= 64'h0;
         dout_valid_q <= 1'b0;
      end else if (din_valid && din_ready) begin
         target_q     <= din;
         cnt_q        <= CW'(CONV_CYCLES - 1);
         state_q      <= CONVERT;
         dout_valid_q <= 1'b0;
      end else if (state_q == CONVERT && cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
      end else if (busy) begin
         cur_q    <= cur_d;
         analog_q <= to_bits(cur_d);
         if (done_d) begin
            state_q      <= HOLD;
            dout_valid_q <= 1'b1;
            conv_done_q  <= 1'b1;
         end
`ifdef DAC_SLEW_LIMIT_EN
         else state_q <= SLEW;
`endif
      end
   end
endmodule
